// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
//
// Two-port arbiter in front of a single shared RAM. The memory stage (me_*)
// and the debug/loader port (dbg_*) each raise a request and hold it until a
// one-cycle ack. One access is serviced at a time: the winner's request
// fields are latched, presented to the RAM for exactly one cycle, the RAM
// read data is captured into the winner's rdata register, and the ack
// pulses in the following cycle.
//
// ME normally has priority. A saturating starvation counter lets DBG win a
// contested arbitration once ME has been granted STARVE_LIMIT times in a row
// while DBG was waiting.
//
// Ports
//   clk                     clock, all state updates on the rising edge
//   rst                     synchronous active-high reset
//   me_req / dbg_req        access request, held until ack
//   me_addr / dbg_addr      byte address, stable while req is high
//   me_wdata / dbg_wdata    store data
//   *_write_ram_flag [1:0]  store-width code, 0 = no store
//   *_read_ram_flag  [2:0]  load-width/sign code, 0 = no load
//   me_ack / dbg_ack        one-cycle completion pulse
//   me_rdata / dbg_rdata    load result, valid in the ack cycle, held after
//   me_stall                pipeline hold, me_req & ~me_ack
//   ram_addr / ram_wdata    shared RAM address / store data
//   ram_write_ram_flag      shared RAM store-width code
//   ram_read_ram_flag       shared RAM load-width code
//   ram_out                 combinational RAM read data
// ---------------------------------------------------------------------------
//
// state   | meaning
// --------+------------------------------------------------------------------
// IDLE    | nothing in flight; arbitrate among requests
// ACC     | latched winner drives the RAM; ram_out captured at cycle end
// DONE    | winner's ack pulses; arbitrate again with the acked side excluded
//
module ram_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,

   input  logic        me_req,
   input  logic [31:0] me_addr,
   input  logic [31:0] me_wdata,
   input  logic [1:0]  me_write_ram_flag,
   input  logic [2:0]  me_read_ram_flag,
   output logic        me_ack,
   output logic [31:0] me_rdata,
   output logic        me_stall,

   input  logic        dbg_req,
   input  logic [31:0] dbg_addr,
   input  logic [31:0] dbg_wdata,
   input  logic [1:0]  dbg_write_ram_flag,
   input  logic [2:0]  dbg_read_ram_flag,
   output logic        dbg_ack,
   output logic [31:0] dbg_rdata,

   output logic [31:0] ram_addr,
   output logic [31:0] ram_wdata,
   output logic [1:0]  ram_write_ram_flag,
   output logic [2:0]  ram_read_ram_flag,
   input  logic [31:0] ram_out
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

   state_t      state_q, state_d;
   logic        win_dbg_q, win_dbg_d;
   logic [31:0] lat_addr_q, lat_addr_d;
   logic [31:0] lat_wdata_q, lat_wdata_d;
   logic [1:0]  lat_wflag_q, lat_wflag_d;
   logic [2:0]  lat_rflag_q, lat_rflag_d;
   logic [2:0]  starve_q, starve_d;
   logic        me_ack_q, me_ack_d;
   logic        dbg_ack_q, dbg_ack_d;
   logic [31:0] me_rdata_q, me_rdata_d;
   logic [31:0] dbg_rdata_q, dbg_rdata_d;

   logic        arb_en;
   logic        me_elig;
   logic        dbg_elig;
   logic        starved;
   logic        grant_me;
   logic        grant_dbg;
   logic        in_acc;

   // ------------------------------------------------------------------------
   // Arbitration. In DONE the side being acked still holds its old request,
   // so it must not be granted again in the same cycle.
   // ------------------------------------------------------------------------
   always_comb begin
      arb_en    = (state_q == ST_IDLE) || (state_q == ST_DONE);
      me_elig   = me_req  && !((state_q == ST_DONE) && !win_dbg_q);
      dbg_elig  = dbg_req && !((state_q == ST_DONE) &&  win_dbg_q);
      starved   = (starve_q == LIMIT);
      grant_dbg = arb_en && dbg_elig && (!me_elig || starved);
      grant_me  = arb_en && me_elig  && !grant_dbg;
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      win_dbg_d   = win_dbg_q;
      lat_addr_d  = lat_addr_q;
      lat_wdata_d = lat_wdata_q;
      lat_wflag_d = lat_wflag_q;
      lat_rflag_d = lat_rflag_q;
      me_ack_d    = 1'b0;
      dbg_ack_d   = 1'b0;
      me_rdata_d  = me_rdata_q;
      dbg_rdata_d = dbg_rdata_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (grant_me || grant_dbg) begin
               state_d   = ST_ACC;
               win_dbg_d = grant_dbg;
               if (grant_dbg) begin
                  lat_addr_d  = dbg_addr;
                  lat_wdata_d = dbg_wdata;
                  lat_wflag_d = dbg_write_ram_flag;
                  lat_rflag_d = dbg_read_ram_flag;
               end else begin
                  lat_addr_d  = me_addr;
                  lat_wdata_d = me_wdata;
                  lat_wflag_d = me_write_ram_flag;
                  lat_rflag_d = me_read_ram_flag;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_ACC: begin
            // Read data is captured even for store-only or flagless accesses;
            // the requester ignores it in that case.
            state_d = ST_DONE;
            if (win_dbg_q) begin
               dbg_rdata_d = ram_out;
               dbg_ack_d   = 1'b1;
            end else begin
               me_rdata_d  = ram_out;
               me_ack_d    = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (!dbg_req || grant_dbg) begin
         starve_d = 3'd0;
      end else if (grant_me && (starve_q < LIMIT)) begin
         starve_d = starve_q + 3'd1;
      end else begin
         starve_d = starve_q;
      end
   end

   // ------------------------------------------------------------------------
   // State and registered outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         win_dbg_q   <= 1'b0;
         lat_addr_q  <= 32'd0;
         lat_wdata_q <= 32'd0;
         lat_wflag_q <= 2'd0;
         lat_rflag_q <= 3'd0;
         starve_q    <= 3'd0;
         me_ack_q    <= 1'b0;
         dbg_ack_q   <= 1'b0;
         me_rdata_q  <= 32'd0;
         dbg_rdata_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         win_dbg_q   <= win_dbg_d;
         lat_addr_q  <= lat_addr_d;
         lat_wdata_q <= lat_wdata_d;
         lat_wflag_q <= lat_wflag_d;
         lat_rflag_q <= lat_rflag_d;
         starve_q    <= starve_d;
         me_ack_q    <= me_ack_d;
         dbg_ack_q   <= dbg_ack_d;
         me_rdata_q  <= me_rdata_d;
         dbg_rdata_q <= dbg_rdata_d;
      end
   end

   // ------------------------------------------------------------------------
   // RAM side. The flags are gated by rst directly so that a store latched
   // in ACC is never committed by the RAM while reset is being applied.
   // ------------------------------------------------------------------------
   always_comb begin
      in_acc             = (state_q == ST_ACC);
      ram_addr           = in_acc ? lat_addr_q  : 32'd0;
      ram_wdata          = in_acc ? lat_wdata_q : 32'd0;
      ram_write_ram_flag = (in_acc && !rst) ? lat_wflag_q : 2'd0;
      ram_read_ram_flag  = (in_acc && !rst) ? lat_rflag_q : 3'd0;
   end

   assign me_ack    = me_ack_q;
   assign dbg_ack   = dbg_ack_q;
   assign me_rdata  = me_rdata_q;
   assign dbg_rdata = dbg_rdata_q;
   assign me_stall  = me_req & ~me_ack_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_arbiter
//
// Drives ram_arbiter against a small word-addressed RAM and compares every
// cycle with a transaction-level model: a grant at cycle g occupies the RAM
// at g+1 and acks at g+2, the next arbitration may happen at g+2 with the
// acked side excluded. Directed scenarios are followed by random traffic.
// ---------------------------------------------------------------------------
module tb_ram_arbiter;

   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        me_req, dbg_req;
   logic [31:0] me_addr, dbg_addr, me_wdata, dbg_wdata;
   logic [1:0]  me_write_ram_flag, dbg_write_ram_flag;
   logic [2:0]  me_read_ram_flag, dbg_read_ram_flag;
   logic        me_ack, dbg_ack, me_stall;
   logic [31:0] me_rdata, dbg_rdata;
   logic [31:0] ram_addr, ram_wdata, ram_out;
   logic [1:0]  ram_write_ram_flag;
   logic [2:0]  ram_read_ram_flag;

   int n_chk = 0;
   int n_err = 0;

   ram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk                (clk),
      .rst                (rst),
      .me_req             (me_req),
      .me_addr            (me_addr),
      .me_wdata           (me_wdata),
      .me_write_ram_flag  (me_write_ram_flag),
      .me_read_ram_flag   (me_read_ram_flag),
      .me_ack             (me_ack),
      .me_rdata           (me_rdata),
      .me_stall           (me_stall),
      .dbg_req            (dbg_req),
      .dbg_addr           (dbg_addr),
      .dbg_wdata          (dbg_wdata),
      .dbg_write_ram_flag (dbg_write_ram_flag),
      .dbg_read_ram_flag  (dbg_read_ram_flag),
      .dbg_ack            (dbg_ack),
      .dbg_rdata          (dbg_rdata),
      .ram_addr           (ram_addr),
      .ram_wdata          (ram_wdata),
      .ram_write_ram_flag (ram_write_ram_flag),
      .ram_read_ram_flag  (ram_read_ram_flag),
      .ram_out            (ram_out)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] init_word(input int i);
      if (i == 4) return 32'hDEADBEEF;
      return 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
   endfunction

   // Shared RAM: combinational read, written on clk.
   logic [31:0] ram_mem [64];
   assign ram_out = ram_mem[ram_addr[7:2]];

   initial begin : ram_model
      for (int i = 0; i < 64; i++) ram_mem[i] = init_word(i);
      forever begin
         @(posedge clk);
         if (ram_write_ram_flag != 2'd0) ram_mem[ram_addr[7:2]] <= ram_wdata;
      end
   end

   // ------------------------------------------------------------------------
   // Reference model, evaluated mid-cycle
   // ------------------------------------------------------------------------
   initial begin : ref_model
      logic [31:0] ref_mem [64];
      int          t, acc_t, ack_t, free_t, starve;
      bit          own_dbg, live;
      logic [31:0] l_addr, l_wdata, pend_rd, exp_me_rd, exp_dbg_rd;
      logic [1:0]  l_wf;
      logic [2:0]  l_rf;
      bit          e_me_ack, e_dbg_ack, me_e, dbg_e, g_me, g_dbg;

      for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
      t = 0; acc_t = -10; ack_t = -10; free_t = 0; starve = 0;
      own_dbg = 1'b0; live = 1'b0;
      l_addr = '0; l_wdata = '0; l_wf = '0; l_rf = '0;
      pend_rd = '0; exp_me_rd = '0; exp_dbg_rd = '0;

      forever begin
         @(negedge clk);
         t++;
         if (rst) begin
            if (live) begin
               chk("rst_wflag", 32'(ram_write_ram_flag), 32'd0);
               chk("rst_rflag", 32'(ram_read_ram_flag), 32'd0);
            end
            live = 1'b1;
            acc_t = -10; ack_t = -10; free_t = t + 1; starve = 0;
            exp_me_rd = '0; exp_dbg_rd = '0;
         end else if (live) begin
            e_me_ack  = (t == ack_t) && !own_dbg;
            e_dbg_ack = (t == ack_t) &&  own_dbg;
            if (e_me_ack)  exp_me_rd  = pend_rd;
            if (e_dbg_ack) exp_dbg_rd = pend_rd;

            chk("me_ack", 32'(me_ack), 32'(e_me_ack));
            chk("dbg_ack", 32'(dbg_ack), 32'(e_dbg_ack));
            chk("ack_excl", 32'(me_ack & dbg_ack), 32'd0);
            chk("me_rdata", me_rdata, exp_me_rd);
            chk("dbg_rdata", dbg_rdata, exp_dbg_rd);
            chk("me_stall", 32'(me_stall), 32'(me_req & ~e_me_ack));

            if (t == acc_t) begin
               chk("acc_addr", ram_addr, l_addr);
               chk("acc_wdata", ram_wdata, l_wdata);
               chk("acc_wflag", 32'(ram_write_ram_flag), 32'(l_wf));
               chk("acc_rflag", 32'(ram_read_ram_flag), 32'(l_rf));
               pend_rd = ref_mem[l_addr[7:2]];
               if (l_wf != 2'd0) ref_mem[l_addr[7:2]] = l_wdata;
            end else begin
               chk("idle_addr", ram_addr, 32'd0);
               chk("idle_wdata", ram_wdata, 32'd0);
               chk("idle_wflag", 32'(ram_write_ram_flag), 32'd0);
               chk("idle_rflag", 32'(ram_read_ram_flag), 32'd0);
            end

            g_me = 1'b0; g_dbg = 1'b0;
            if (t >= free_t) begin
               me_e  = me_req  && !e_me_ack;
               dbg_e = dbg_req && !e_dbg_ack;
               g_dbg = dbg_e && (!me_e || starve == LIMIT);
               g_me  = me_e && !g_dbg;
               if (g_me || g_dbg) begin
                  own_dbg = g_dbg;
                  l_addr  = g_dbg ? dbg_addr  : me_addr;
                  l_wdata = g_dbg ? dbg_wdata : me_wdata;
                  l_wf    = g_dbg ? dbg_write_ram_flag : me_write_ram_flag;
                  l_rf    = g_dbg ? dbg_read_ram_flag  : me_read_ram_flag;
                  acc_t = t + 1; ack_t = t + 2; free_t = t + 2;
               end
            end
            if (!dbg_req || g_dbg) starve = 0;
            else if (g_me && starve < LIMIT) starve++;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic me_set(input logic r, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] wf, input logic [2:0] rf);
      me_req = r; me_addr = a; me_wdata = d;
      me_write_ram_flag = wf; me_read_ram_flag = rf;
   endtask

   task automatic dbg_set(input logic r, input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] wf, input logic [2:0] rf);
      dbg_req = r; dbg_addr = a; dbg_wdata = d;
      dbg_write_ram_flag = wf; dbg_read_ram_flag = rf;
   endtask

   initial begin : stim
      bit me_seen, dbg_seen;
      int run, max_run, dbg_n, me_n;

      rst = 1'b1;
      me_set(1'b0, 32'd0, 32'd0, 2'd0, 3'd0);
      dbg_set(1'b0, 32'd0, 32'd0, 2'd0, 3'd0);
      repeat (3) tick();
      rst = 1'b0;
      mid();
      chk("reset_me_ack", 32'(me_ack), 32'd0);
      chk("reset_me_rdata", me_rdata, 32'd0);
      chk("reset_dbg_rdata", dbg_rdata, 32'd0);
      tick();

      // ME load of word 0x10
      me_set(1'b1, 32'h10, 32'd0, 2'd0, 3'd3);
      mid(); chk("ld_stall_c0", 32'(me_stall), 32'd1);
      tick(); mid();
      chk("ld_rflag_c1", 32'(ram_read_ram_flag != 3'd0), 32'd1);
      chk("ld_stall_c1", 32'(me_stall), 32'd1);
      tick(); mid();
      chk("ld_ack_c2", 32'(me_ack), 32'd1);
      chk("ld_rdata_c2", me_rdata, 32'hDEADBEEF);
      chk("ld_stall_c2", 32'(me_stall), 32'd0);
      tick(); me_req = 1'b0;
      repeat (2) tick();

      // Simultaneous ME and DBG: ME first, DBG back-to-back
      me_set(1'b1, 32'h40, 32'd0, 2'd0, 3'd3);
      dbg_set(1'b1, 32'h44, 32'd0, 2'd0, 3'd3);
      tick(); mid(); chk("both_c1_addr", ram_addr, 32'h40);
      tick(); mid();
      chk("both_c2_me_ack", 32'(me_ack), 32'd1);
      chk("both_c2_dbg_ack", 32'(dbg_ack), 32'd0);
      tick(); me_req = 1'b0; mid();
      chk("both_c3_addr", ram_addr, 32'h44);
      chk("both_c3_rflag", 32'(ram_read_ram_flag != 3'd0), 32'd1);
      tick(); mid();
      chk("both_c4_dbg_ack", 32'(dbg_ack), 32'd1);
      chk("both_c4_me_ack", 32'(me_ack), 32'd0);
      chk("both_c4_dbg_rdata", dbg_rdata, init_word(17));
      tick(); dbg_req = 1'b0;
      repeat (2) tick();

      // DBG store then ME load of the same word
      dbg_set(1'b1, 32'h20, 32'h12345678, 2'd3, 3'd0);
      tick(); tick(); mid();
      chk("st_dbg_ack", 32'(dbg_ack), 32'd1);
      tick();
      dbg_req = 1'b0;
      me_set(1'b1, 32'h20, 32'd0, 2'd0, 3'd3);
      tick(); tick(); mid();
      chk("st_me_ack", 32'(me_ack), 32'd1);
      chk("st_me_rdata", me_rdata, 32'h12345678);
      tick(); me_req = 1'b0;
      repeat (2) tick();

      // Reset during ACC of an ME store
      me_set(1'b1, 32'h30, 32'hCAFEF00D, 2'd3, 3'd0);
      tick();
      rst = 1'b1; me_req = 1'b0;
      mid(); chk("rstacc_wflag", 32'(ram_write_ram_flag), 32'd0);
      tick();
      rst = 1'b0;
      me_set(1'b1, 32'h30, 32'd0, 2'd0, 3'd3);
      mid();
      chk("rstacc_no_ack", 32'(me_ack), 32'd0);
      chk("rstacc_ram_kept", ram_mem[12], init_word(12));
      tick(); mid();
      chk("rstacc_fresh_acc", 32'(ram_read_ram_flag != 3'd0), 32'd1);
      tick(); mid();
      chk("rstacc_fresh_ack", 32'(me_ack), 32'd1);
      chk("rstacc_fresh_rdata", me_rdata, init_word(12));
      tick(); me_req = 1'b0;
      repeat (2) tick();

      // ME continuously requesting with DBG held: DBG must not wait longer
      // than STARVE_LIMIT ME grants.
      me_set(1'b1, 32'h0C, 32'd0, 2'd0, 3'd3);
      dbg_set(1'b1, 32'h08, 32'd0, 2'd0, 3'd3);
      run = 0; max_run = 0; dbg_n = 0; me_n = 0;
      for (int c = 0; c < 40; c++) begin
         mid();
         if (me_ack) begin me_n++; run++; end
         if (dbg_ack) begin
            dbg_n++;
            if (run > max_run) max_run = run;
            run = 0;
         end
         tick();
      end
      if (run > max_run) max_run = run;
      chk("starve_bound", 32'(max_run <= LIMIT), 32'd1);
      chk("starve_dbg_served", 32'(dbg_n > 0), 32'd1);
      chk("starve_me_served", 32'(me_n > 0), 32'd1);
      me_req = 1'b0; dbg_req = 1'b0;
      repeat (3) tick();

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         mid();
         me_seen  = me_ack;
         dbg_seen = dbg_ack;
         tick();
         rst = ($urandom_range(0, 199) == 0);
         if (me_req && (me_seen || $urandom_range(0, 31) == 0)) me_req = 1'b0;
         if (!me_req && $urandom_range(0, 2) != 0)
            me_set(1'b1, {24'd0, 6'($urandom_range(0, 63)), 2'b00}, $urandom,
                   2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
         if (dbg_req && (dbg_seen || $urandom_range(0, 31) == 0)) dbg_req = 1'b0;
         if (!dbg_req && $urandom_range(0, 3) == 0)
            dbg_set(1'b1, {24'd0, 6'($urandom_range(0, 63)), 2'b00}, $urandom,
                    2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
      end
      rst = 1'b0; me_req = 1'b0; dbg_req = 1'b0;
      repeat (4) tick();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
